// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psram_pkg
//  Description : Command opcodes and state encoding for the PSRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
package psram_pkg;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QPI_EX = 8'hF5;
    localparam logic [7:0] CMD_RST_EN = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_RD    = 3'd4,
        ST_WR    = 3'd5,
        ST_SKIP  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psram_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : psram_sync_edge
//  Description : Two-flop synchroniser followed by a rise/fall edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module psram_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_d  <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_d;
    assign o_fall = ~r_s2 & r_d;

endmodule
`default_nettype wire

// File: rtl/psram_qspi_model.sv
`default_nettype none
// ============================================================================
//  Module      : psram_qspi_model
//  Description : HCLK-oversampled QSPI/QPI PSRAM device model (0xEB/0x38/0x03).
//  Revision    : 1.0 - initial release
// ============================================================================
module psram_qspi_model
    import psram_pkg::*;
#(
    parameter int MEM_DEPTH = 8192,
    parameter int ADDR_W    = 24,
    parameter int RD_DUMMY  = 6
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] dio_i,
    output logic [3:0] dio_o,
    output logic       dio_oe,
    output logic       qpi_mode,
    output logic       busy
);

    localparam int AW_M  = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(ADDR_W + 16);

    localparam logic [CNT_W-1:0] c_ADDR_Q_LAST = CNT_W'(ADDR_W / 4 - 1);
    localparam logic [CNT_W-1:0] c_ADDR_S_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] c_DUMMY_LAST  = CNT_W'(RD_DUMMY - 1);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_SEVEN       = CNT_W'(7);

    logic w_sck_rise, w_sck_fall, w_cs_end, w_cs_start;

    psram_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .i_d    (sck),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    psram_sync_edge #(.RST_VAL(1'b1)) u_sync_ce (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .i_d    (ce_n),
        .o_rise (w_cs_end),
        .o_fall (w_cs_start)
    );

    // Data lines share the two-stage latency of sck so a sampled nibble lines up with its rise.
    logic [3:0] r_dio_s1, r_dio_s2;
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_dio_s1 <= 4'h0;
            r_dio_s2 <= 4'h0;
        end else begin
            r_dio_s1 <= dio_i;
            r_dio_s2 <= r_dio_s1;
        end
    end

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cmd, w_cmd_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [AW_M-1:0]  r_addr, w_addr_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [3:0]       r_wr_hi, w_wr_hi_nxt;
    logic             r_wr_nib, w_wr_nib_nxt;
    logic [3:0]       r_dio_o, w_dio_o_nxt;
    logic             r_oe, w_oe_nxt;
    logic             r_qpi, w_qpi_nxt;
    logic             r_rst_en, w_rst_en_nxt;
    logic             r_busy, w_busy_nxt;

    logic [7:0]       r_mem [MEM_DEPTH];
    logic             w_we;
    logic [7:0]       w_wdata;
    logic [AW_M-1:0]  w_rd_idx;
    logic [7:0]       w_rd_byte;

    logic [7:0]       w_cmd_sh;
    logic             w_cmd_done;
    logic             w_quad;
    logic [AW_M-1:0]  w_addr_sh;
    logic             w_addr_done;
    logic             w_rd_last;

    assign w_cmd_sh    = r_qpi ? {r_cmd[3:0], r_dio_s2} : {r_cmd[6:0], r_dio_s2[0]};
    assign w_cmd_done  = r_qpi ? (r_cnt == c_ONE) : (r_cnt == c_SEVEN);
    assign w_quad      = (r_cmd != CMD_READ);
    // Only the low AW_M address bits are kept; upper bits shift out and are lost.
    assign w_addr_sh   = w_quad ? {r_addr[AW_M-5:0], r_dio_s2} : {r_addr[AW_M-2:0], r_dio_s2[0]};
    assign w_addr_done = w_quad ? (r_cnt == c_ADDR_Q_LAST) : (r_cnt == c_ADDR_S_LAST);
    assign w_rd_last   = w_quad ? (r_cnt == c_ONE) : (r_cnt == c_SEVEN);
    assign w_rd_idx    = (r_state == ST_ADDR) ? w_addr_sh : r_addr;
    assign w_rd_byte   = r_mem[w_rd_idx];

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_nxt    = r_cmd;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_shift_nxt  = r_shift;
        w_wr_hi_nxt  = r_wr_hi;
        w_wr_nib_nxt = r_wr_nib;
        w_dio_o_nxt  = r_dio_o;
        w_oe_nxt     = r_oe;
        w_qpi_nxt    = r_qpi;
        w_rst_en_nxt = r_rst_en;
        w_busy_nxt   = w_cs_end ? 1'b0 : (w_cs_start ? 1'b1 : r_busy);
        w_we         = 1'b0;
        w_wdata      = 8'h00;

        if (w_cs_end) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
            w_dio_o_nxt = 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_start) begin
                        w_state_nxt = ST_CMD;
                        w_cnt_nxt   = '0;
                        w_cmd_nxt   = 8'h00;
                    end
                end
                ST_CMD: begin
                    if (w_sck_rise) begin
                        w_cmd_nxt = w_cmd_sh;
                        w_cnt_nxt = r_cnt + c_ONE;
                        if (w_cmd_done) begin
                            w_cnt_nxt    = '0;
                            w_addr_nxt   = '0;
                            w_state_nxt  = ST_SKIP;
                            w_rst_en_nxt = 1'b0;
                            case (w_cmd_sh)
                                CMD_QREAD, CMD_QWRITE, CMD_READ: w_state_nxt = ST_ADDR;
                                CMD_QPI_EN: w_qpi_nxt    = 1'b1;
                                CMD_QPI_EX: w_qpi_nxt    = 1'b0;
                                CMD_RST_EN: w_rst_en_nxt = 1'b1;
                                CMD_RST: begin
                                    w_rst_en_nxt = r_rst_en;
                                    if (r_rst_en) begin
                                        w_qpi_nxt = 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise) begin
                        w_addr_nxt = w_addr_sh;
                        w_cnt_nxt  = r_cnt + c_ONE;
                        if (w_addr_done) begin
                            w_cnt_nxt = '0;
                            if (r_cmd == CMD_QREAD) begin
                                w_state_nxt = ST_DUMMY;
                            end else if (r_cmd == CMD_QWRITE) begin
                                w_state_nxt  = ST_WR;
                                w_wr_nib_nxt = 1'b0;
                            end else begin
                                // Advance past the preloaded byte so every later load is mem[addr].
                                w_state_nxt = ST_RD;
                                w_shift_nxt = w_rd_byte;
                                w_addr_nxt  = w_addr_sh + AW_M'(1);
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (w_sck_rise) begin
                        w_cnt_nxt = r_cnt + c_ONE;
                        if (r_cnt == c_DUMMY_LAST) begin
                            w_cnt_nxt   = '0;
                            w_shift_nxt = w_rd_byte;
                            w_addr_nxt  = r_addr + AW_M'(1);
                            w_state_nxt = ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (w_sck_fall) begin
                        w_oe_nxt    = 1'b1;
                        w_dio_o_nxt = w_quad ? r_shift[7:4] : {2'b00, r_shift[7], 1'b0};
                        w_shift_nxt = w_quad ? {r_shift[3:0], 4'h0} : {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = r_cnt + c_ONE;
                        if (w_rd_last) begin
                            w_cnt_nxt   = '0;
                            w_shift_nxt = w_rd_byte;
                            w_addr_nxt  = r_addr + AW_M'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (w_sck_rise) begin
                        if (!r_wr_nib) begin
                            w_wr_hi_nxt  = r_dio_s2;
                            w_wr_nib_nxt = 1'b1;
                        end else begin
                            w_we         = 1'b1;
                            w_wdata      = {r_wr_hi, r_dio_s2};
                            w_addr_nxt   = r_addr + AW_M'(1);
                            w_wr_nib_nxt = 1'b0;
                        end
                    end
                end
                ST_SKIP: ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state  <= ST_IDLE;
            r_cmd    <= 8'h00;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_shift  <= 8'h00;
            r_wr_hi  <= 4'h0;
            r_wr_nib <= 1'b0;
            r_dio_o  <= 4'h0;
            r_oe     <= 1'b0;
            r_qpi    <= 1'b0;
            r_rst_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cmd    <= w_cmd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_shift  <= w_shift_nxt;
            r_wr_hi  <= w_wr_hi_nxt;
            r_wr_nib <= w_wr_nib_nxt;
            r_dio_o  <= w_dio_o_nxt;
            r_oe     <= w_oe_nxt;
            r_qpi    <= w_qpi_nxt;
            r_rst_en <= w_rst_en_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Storage has no reset so contents survive HRESETn.
    always_ff @(posedge HCLK) begin
        if (HRESETn && w_we) begin
            r_mem[r_addr] <= w_wdata;
        end
    end

    assign dio_o    = r_dio_o;
    assign dio_oe   = r_oe;
    assign qpi_mode = r_qpi;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psram_qspi_model
//  Description : Self-checking bench: vector table, corner sequences, random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_qspi_model;
    import psram_pkg::*;

    localparam int MEM_DEPTH = 8192;
    localparam int ADDR_W    = 24;
    localparam int RD_DUMMY  = 6;
    localparam int PH        = 8;

    logic       HCLK    = 1'b0;
    logic       HRESETn = 1'b0;
    logic       sck     = 1'b0;
    logic       ce_n    = 1'b1;
    logic [3:0] dio_i   = 4'h0;
    logic [3:0] dio_o;
    logic       dio_oe;
    logic       qpi_mode;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic       qpi_m = 1'b0;
    logic [7:0] mem_m [MEM_DEPTH];
    logic [7:0] wdat [8];
    logic [7:0] rdat [8];
    logic       oe_pre;

    psram_qspi_model #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W),
        .RD_DUMMY  (RD_DUMMY)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .sck      (sck),
        .ce_n     (ce_n),
        .dio_i    (dio_i),
        .dio_o    (dio_o),
        .dio_oe   (dio_oe),
        .qpi_mode (qpi_mode),
        .busy     (busy)
    );

    always #5 HCLK = ~HCLK;

    // Bus timing constraint: every sck phase and every ce_n high time lasts >= 6 HCLK.
    int   sck_run = 100;
    int   ce_run  = 100;
    logic sck_q   = 1'b0;
    logic ce_q    = 1'b1;
    always @(posedge HCLK) begin
        if (sck !== sck_q) begin
            assert (sck_run >= 6) else $error("sck phase shorter than 6 HCLK");
            sck_run <= 1;
        end else begin
            sck_run <= sck_run + 1;
        end
        if (ce_n !== ce_q) begin
            if (ce_q == 1'b1) begin
                assert (ce_run >= 6) else $error("ce_n high time shorter than 6 HCLK");
            end
            ce_run <= 1;
        end else begin
            ce_run <= ce_run + 1;
        end
        sck_q <= sck;
        ce_q  <= ce_n;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One sck period: fall, hold low, sample outputs late in the low phase, rise, hold high.
    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic oe);
        sck   = 1'b0;
        dio_i = d;
        wait_clk(PH);
        q  = dio_o;
        oe = dio_oe;
        sck = 1'b1;
        wait_clk(PH);
    endtask

    task automatic cs_begin();
        sck  = 1'b0;
        ce_n = 1'b0;
        wait_clk(PH);
    endtask

    task automatic cs_finish();
        sck = 1'b0;
        wait_clk(PH);
        ce_n = 1'b1;
        wait_clk(PH);
    endtask

    task automatic send_byte_cmd(input logic [7:0] c);
        logic [3:0] q;
        logic       oe;
        if (qpi_m) begin
            sck_cycle(c[7:4], q, oe); oe_pre |= oe;
            sck_cycle(c[3:0], q, oe); oe_pre |= oe;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                sck_cycle({3'b000, c[i]}, q, oe);
                oe_pre |= oe;
            end
        end
    endtask

    task automatic send_addr(input logic [23:0] a, input logic quad);
        logic [3:0] q;
        logic       oe;
        if (quad) begin
            for (int i = 5; i >= 0; i--) begin
                sck_cycle(a[i*4 +: 4], q, oe);
                oe_pre |= oe;
            end
        end else begin
            for (int i = 23; i >= 0; i--) begin
                sck_cycle({3'b000, a[i]}, q, oe);
                oe_pre |= oe;
            end
        end
    endtask

    task automatic simple_cmd(input logic [7:0] c, input string name);
        cs_begin();
        oe_pre = 1'b0;
        send_byte_cmd(c);
        cs_finish();
        check({name, " oe"}, 32'(oe_pre), 32'd0);
    endtask

    // Quad write of n bytes; extra>0 appends a dangling high nibble before ce_n rises.
    task automatic do_write(input logic [23:0] a, input int n, input int extra);
        logic [3:0] q;
        logic       oe;
        cs_begin();
        oe_pre = 1'b0;
        send_byte_cmd(CMD_QWRITE);
        send_addr(a, 1'b1);
        for (int i = 0; i < n; i++) begin
            sck_cycle(wdat[i][7:4], q, oe); oe_pre |= oe;
            sck_cycle(wdat[i][3:0], q, oe); oe_pre |= oe;
        end
        if (extra > 0) begin
            sck_cycle(4'hE, q, oe);
            oe_pre |= oe;
        end
        cs_finish();
        for (int i = 0; i < n; i++) begin
            mem_m[(int'(a) + i) % MEM_DEPTH] = wdat[i];
        end
        check("write oe", 32'(oe_pre), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int n);
        logic [3:0] q, q2;
        logic       oe, oe2;
        logic       oe_all;
        logic       junk;
        cs_begin();
        check("busy in cs", 32'(busy), 32'd1);
        oe_pre = 1'b0;
        send_byte_cmd(cmd);
        send_addr(a, cmd == CMD_QREAD);
        if (cmd == CMD_QREAD) begin
            for (int i = 0; i < RD_DUMMY; i++) begin
                sck_cycle(4'h0, q, oe);
                oe_pre |= oe;
            end
        end
        check("oe before data", 32'(oe_pre), 32'd0);
        oe_all = 1'b1;
        junk   = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (cmd == CMD_QREAD) begin
                sck_cycle(4'h0, q, oe);
                sck_cycle(4'h0, q2, oe2);
                rdat[b] = {q, q2};
                oe_all &= oe & oe2;
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    sck_cycle(4'h0, q, oe);
                    rdat[b][i] = q[1];
                    oe_all &= oe;
                    junk |= q[3] | q[2] | q[0];
                end
            end
        end
        cs_finish();
        check("oe during data", 32'(oe_all), 32'd1);
        if (cmd == CMD_READ) begin
            check("spi unused lines", 32'(junk), 32'd0);
        end
        check("oe after cs", 32'(dio_oe), 32'd0);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] cmd;
        logic [23:0] addr;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    vec_t vec [7];

    logic [3:0] tq;
    logic       toe;

    initial begin
        vec[0] = '{1'b1, CMD_QWRITE, 24'h000010, 8'hA5, 8'h3C};
        vec[1] = '{1'b0, CMD_QREAD,  24'h000010, 8'hA5, 8'h3C};
        vec[2] = '{1'b1, CMD_QWRITE, 24'h001FFF, 8'h11, 8'h22};
        vec[3] = '{1'b0, CMD_QREAD,  24'h001FFF, 8'h11, 8'h22};
        vec[4] = '{1'b0, CMD_READ,   24'h000010, 8'hA5, 8'h3C};
        vec[5] = '{1'b0, CMD_QREAD,  24'hFF0010, 8'hA5, 8'h3C};
        vec[6] = '{1'b0, CMD_READ,   24'h001FFF, 8'h11, 8'h22};

        wait_clk(4);
        check("reset dio_oe", 32'(dio_oe), 32'd0);
        check("reset dio_o", 32'(dio_o), 32'd0);
        check("reset qpi_mode", 32'(qpi_mode), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        HRESETn = 1'b1;
        wait_clk(PH);

        for (int i = 0; i < 7; i++) begin
            if (vec[i].wr) begin
                wdat[0] = vec[i].b0;
                wdat[1] = vec[i].b1;
                do_write(vec[i].addr, 2, 0);
            end else begin
                do_read(vec[i].cmd, vec[i].addr, 2);
                check($sformatf("vec%0d byte0", i), 32'(rdat[0]), 32'(vec[i].b0));
                check($sformatf("vec%0d byte1", i), 32'(rdat[1]), 32'(vec[i].b1));
            end
        end

        // QPI entry, QPI-mode read, reset-enable/reset pair, lone reset.
        simple_cmd(CMD_QPI_EN, "qpi enter");
        check("qpi after 0x35", 32'(qpi_mode), 32'd1);
        qpi_m = 1'b1;
        do_read(CMD_QREAD, 24'h000010, 2);
        check("qpi read byte0", 32'(rdat[0]), 32'hA5);
        check("qpi read byte1", 32'(rdat[1]), 32'h3C);
        simple_cmd(CMD_RST_EN, "rst enable");
        check("qpi after 0x66", 32'(qpi_mode), 32'd1);
        simple_cmd(CMD_RST, "rst");
        check("qpi after 0x66 0x99", 32'(qpi_mode), 32'd0);
        qpi_m = 1'b0;
        simple_cmd(CMD_QPI_EN, "qpi enter again");
        qpi_m = 1'b1;
        simple_cmd(CMD_RST, "lone rst");
        check("qpi after lone 0x99", 32'(qpi_mode), 32'd1);
        simple_cmd(CMD_QPI_EX, "qpi exit");
        check("qpi after 0xF5", 32'(qpi_mode), 32'd0);
        qpi_m = 1'b0;

        // Partial write: the trailing lone nibble must not touch 0x21.
        wdat[0] = 8'h5A;
        wdat[1] = 8'h6B;
        do_write(24'h000020, 2, 0);
        wdat[0] = 8'hCD;
        do_write(24'h000020, 1, 1);
        do_read(CMD_QREAD, 24'h000020, 2);
        check("partial byte 0x20", 32'(rdat[0]), 32'hCD);
        check("partial byte 0x21 kept", 32'(rdat[1]), 32'h6B);

        // ce_n rising in the middle of a read drops dio_oe within 4 HCLK.
        cs_begin();
        send_byte_cmd(CMD_QREAD);
        send_addr(24'h000010, 1'b1);
        for (int i = 0; i < RD_DUMMY; i++) sck_cycle(4'h0, tq, toe);
        sck_cycle(4'h0, tq, toe);
        sck_cycle(4'h0, tq, toe);
        check("oe before abort", 32'(toe), 32'd1);
        ce_n = 1'b1;
        wait_clk(4);
        check("oe 4 clk after ce_n rise", 32'(dio_oe), 32'd0);
        sck = 1'b0;
        wait_clk(PH);

        // HRESETn asserted mid-read while in QPI mode.
        simple_cmd(CMD_QPI_EN, "qpi before reset");
        qpi_m = 1'b1;
        check("qpi before reset", 32'(qpi_mode), 32'd1);
        cs_begin();
        send_byte_cmd(CMD_QREAD);
        send_addr(24'h000010, 1'b1);
        for (int i = 0; i < RD_DUMMY; i++) sck_cycle(4'h0, tq, toe);
        sck_cycle(4'h0, tq, toe);
        HRESETn = 1'b0;
        wait_clk(1);
        check("mid-read reset dio_oe", 32'(dio_oe), 32'd0);
        check("mid-read reset qpi_mode", 32'(qpi_mode), 32'd0);
        check("mid-read reset dio_o", 32'(dio_o), 32'd0);
        check("mid-read reset busy", 32'(busy), 32'd0);
        ce_n = 1'b1;
        sck  = 1'b0;
        wait_clk(PH);
        HRESETn = 1'b1;
        wait_clk(PH);
        qpi_m = 1'b0;
        do_read(CMD_QREAD, 24'h000010, 2);
        check("mem kept byte0", 32'(rdat[0]), 32'hA5);
        check("mem kept byte1", 32'(rdat[1]), 32'h3C);

        // Random bursts, some straddling the top of memory, checked against the array model.
        for (int it = 0; it < 14; it++) begin
            logic [23:0] a;
            logic [7:0]  c;
            int          n, k, m;
            a = 24'($urandom);
            if (it % 3 == 0) a[12:0] = 13'h1FFC + 13'($urandom_range(0, 3));
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
            do_write(a, n, 0);
            k = int'($urandom_range(0, n - 1));
            m = int'($urandom_range(1, n - k));
            c = ($urandom_range(0, 1) == 1) ? CMD_QREAD : CMD_READ;
            do_read(c, a + 24'(k), m);
            for (int i = 0; i < m; i++) begin
                check($sformatf("rand%0d byte%0d", it, i), 32'(rdat[i]),
                      32'(mem_m[(int'(a) + k + i) % MEM_DEPTH]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
